// File: rtl/glyph_pkg.sv
// Shared definitions for the glyph row reader: sheet IDs, glyph codes,
// glyph heights and the reader FSM state type.
package glyph_pkg;

  // ROM sheet identifiers
  localparam logic [1:0] SheetDigits = 2'd0;
  localparam logic [1:0] SheetAmPm   = 2'd1;
  localparam logic [1:0] Sheet24h    = 2'd2;
  localparam logic [1:0] SheetColour = 2'd3;

  // Glyph request codes
  localparam logic [3:0] CodeDigit0  = 4'd0;
  localparam logic [3:0] CodeDigit1  = 4'd1;
  localparam logic [3:0] CodeDigit2  = 4'd2;
  localparam logic [3:0] CodeDigit3  = 4'd3;
  localparam logic [3:0] CodeDigit4  = 4'd4;
  localparam logic [3:0] CodeDigit5  = 4'd5;
  localparam logic [3:0] CodeDigit6  = 4'd6;
  localparam logic [3:0] CodeDigit7  = 4'd7;
  localparam logic [3:0] CodeDigit8  = 4'd8;
  localparam logic [3:0] CodeDigit9  = 4'd9;
  localparam logic [3:0] CodeAm      = 4'd10;
  localparam logic [3:0] CodePm      = 4'd11;
  localparam logic [3:0] Code24h     = 4'd12;
  localparam logic [3:0] CodeRed     = 4'd13;
  localparam logic [3:0] CodeGreen   = 4'd14;
  localparam logic [3:0] CodeInvalid = 4'd15;

  // Glyph heights in rows
  localparam int unsigned DigitHeight = 60;
  localparam int unsigned LabelHeight = 20;

  // Reader FSM states
  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StCapture,
    StPresent
  } state_e;

endpackage

// File: rtl/glyph_base_lut.sv
// Combinational map from glyph code to ROM base row, glyph height, sheet and
// a validity flag. Labels sharing a sheet are stacked at row 0 and row 20.
module glyph_base_lut
  import glyph_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic [3:0]        code_i,
  output logic [ADDR_W-1:0] base_o,
  output logic [5:0]        height_o,
  output logic [1:0]        sheet_o,
  output logic              valid_o
);

  // Decode the request code into its glyph placement
  always_comb begin
    base_o   = '0;
    height_o = 6'(LabelHeight);
    sheet_o  = SheetDigits;
    valid_o  = 1'b1;
    unique case (code_i)
      CodeDigit0, CodeDigit1, CodeDigit2, CodeDigit3, CodeDigit4,
      CodeDigit5, CodeDigit6, CodeDigit7, CodeDigit8, CodeDigit9: begin
        base_o   = ADDR_W'(int'(code_i) * DigitHeight);
        height_o = 6'(DigitHeight);
        sheet_o  = SheetDigits;
      end
      CodeAm: begin
        base_o  = '0;
        sheet_o = SheetAmPm;
      end
      CodePm: begin
        base_o  = ADDR_W'(LabelHeight);
        sheet_o = SheetAmPm;
      end
      Code24h: begin
        base_o  = '0;
        sheet_o = Sheet24h;
      end
      CodeRed: begin
        base_o  = '0;
        sheet_o = SheetColour;
      end
      CodeGreen: begin
        base_o  = ADDR_W'(LabelHeight);
        sheet_o = SheetColour;
      end
      CodeInvalid: begin
        valid_o = 1'b0;
      end
      default: begin
        valid_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/glyph_row_reader.sv
// Glyph row reader: fetches a glyph from the font ROM one row at a time and
// presents each row with a valid/ready handshake (3 cycles per row).
// Optional feature: define GLYPH_ROW_READER_ABORT_EN to add an abort input
// that returns the reader to idle from any busy state.
module glyph_row_reader
  import glyph_pkg::*;
#(
  parameter int unsigned ROW_W  = 40,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
`ifdef GLYPH_ROW_READER_ABORT_EN
  input  logic              abort,
`endif
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_value,
  output logic              rom_en,
  output logic [1:0]        rom_sheet,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [ROW_W-1:0]  rom_data,
  output logic              row_valid,
  input  logic              row_ready,
  output logic [ROW_W-1:0]  row_data,
  output logic [5:0]        row_index,
  output logic              row_last,
  output logic              err
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [5:0]          height_q, height_d;
  logic [5:0]          row_index_q, row_index_d;
  logic [ROW_W-1:0]    row_data_q, row_data_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic [1:0]          rom_sheet_q, rom_sheet_d;
  logic                err_q, err_d;

  logic [ADDR_W-1:0]   lut_base;
  logic [5:0]          lut_height;
  logic [1:0]          lut_sheet;
  logic                lut_valid;

  glyph_base_lut #(
    .ADDR_W (ADDR_W)
  ) u_lut (
    .code_i   (req_value),
    .base_o   (lut_base),
    .height_o (lut_height),
    .sheet_o  (lut_sheet),
    .valid_o  (lut_valid)
  );

  // Next-state logic; ROM address/sheet are registers so they hold outside ISSUE
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    height_d    = height_q;
    row_index_d = row_index_q;
    row_data_d  = row_data_q;
    rom_addr_d  = rom_addr_q;
    rom_sheet_d = rom_sheet_q;
    err_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (lut_valid) begin
            base_d      = lut_base;
            height_d    = lut_height;
            rom_sheet_d = lut_sheet;
            rom_addr_d  = lut_base;
            row_index_d = '0;
            state_d     = StIssue;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StIssue: begin
        state_d = StCapture;
      end
      StCapture: begin
        // ROM data is valid exactly one cycle after the strobe
        row_data_d = rom_data;
        state_d    = StPresent;
      end
      StPresent: begin
        if (row_ready) begin
          if (row_last) begin
            state_d = StIdle;
          end else begin
            row_index_d = row_index_q + 6'd1;
            rom_addr_d  = base_q + ADDR_W'(row_index_q) + ADDR_W'(1);
            state_d     = StIssue;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

`ifdef GLYPH_ROW_READER_ABORT_EN
    // Abort wins over a coincident row handshake; nothing else advances
    if (abort && (state_q != StIdle)) begin
      state_d     = StIdle;
      row_index_d = row_index_q;
      rom_addr_d  = rom_addr_q;
      row_data_d  = row_data_q;
    end
`endif
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      base_q      <= '0;
      height_q    <= '0;
      row_index_q <= '0;
      row_data_q  <= '0;
      rom_addr_q  <= '0;
      rom_sheet_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      height_q    <= height_d;
      row_index_q <= row_index_d;
      row_data_q  <= row_data_d;
      rom_addr_q  <= rom_addr_d;
      rom_sheet_q <= rom_sheet_d;
      err_q       <= err_d;
    end
  end

  // Outputs decoded from state; height 0 after reset keeps row_last low
  always_comb begin
    req_ready = (state_q == StIdle);
    rom_en    = (state_q == StIssue);
    row_valid = (state_q == StPresent);
    row_last  = (row_index_q == (height_q - 6'd1));
    rom_addr  = rom_addr_q;
    rom_sheet = rom_sheet_q;
    row_data  = row_data_q;
    row_index = row_index_q;
    err       = err_q;
  end

endmodule

// File: tb/tb_glyph_row_reader.sv
// Directed self-checking bench for glyph_row_reader. A small ROM model returns
// a word encoding sheet and address so every captured row can be predicted.
module tb_glyph_row_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_value;
  logic        rom_en;
  logic [1:0]  rom_sheet;
  logic [9:0]  rom_addr;
  logic [39:0] rom_data = '0;
  logic        row_valid;
  logic        row_ready;
  logic [39:0] row_data;
  logic [5:0]  row_index;
  logic        row_last;
  logic        err;
`ifdef GLYPH_ROW_READER_ABORT_EN
  logic        abort;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  glyph_row_reader #(
    .ROW_W  (40),
    .ADDR_W (10)
  ) dut (
    .clk       (clk),
`ifdef GLYPH_ROW_READER_ABORT_EN
    .abort     (abort),
`endif
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_value (req_value),
    .rom_en    (rom_en),
    .rom_sheet (rom_sheet),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .row_data  (row_data),
    .row_index (row_index),
    .row_last  (row_last),
    .err       (err)
  );

  function automatic logic [39:0] rom_word(input int sheet, input int addr);
    logic [1:0] s;
    logic [9:0] a;
    s = sheet[1:0];
    a = addr[9:0];
    return {4'hC, 2'b00, s, 22'd0, a};
  endfunction

  // ROM model: one-cycle read latency
  always @(posedge clk) begin
    if (rom_en) rom_data <= rom_word(int'(rom_sheet), int'(rom_addr));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 1);
    chk({tag, "_rom_en"},    64'(rom_en), 0);
    chk({tag, "_rom_addr"},  64'(rom_addr), 0);
    chk({tag, "_rom_sheet"}, 64'(rom_sheet), 0);
    chk({tag, "_row_valid"}, 64'(row_valid), 0);
    chk({tag, "_row_data"},  64'(row_data), 0);
    chk({tag, "_row_index"}, 64'(row_index), 0);
    chk({tag, "_row_last"},  64'(row_last), 0);
    chk({tag, "_err"},       64'(err), 0);
  endtask

  // Request a glyph and walk its rows. stall: row_ready low cycles on row 0.
  // stop_row >= 0 returns while presenting that row, before its handshake.
  task automatic run_glyph(input logic [3:0] code, input int base, input int height,
                           input int sheet, input int stall, input int stop_row);
    row_ready = (stall == 0);
    chk("idle_req_ready", 64'(req_ready), 1);
    chk("idle_err", 64'(err), 0);
    req_value = code;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int r = 0; r < height; r++) begin
      chk("issue_rom_en", 64'(rom_en), 1);
      chk("issue_rom_addr", 64'(rom_addr), 64'(base + r));
      chk("issue_rom_sheet", 64'(rom_sheet), 64'(sheet));
      chk("issue_row_valid", 64'(row_valid), 0);
      chk("issue_req_ready", 64'(req_ready), 0);
      step();
      chk("capture_rom_en", 64'(rom_en), 0);
      chk("capture_row_valid", 64'(row_valid), 0);
      step();
      chk("present_row_valid", 64'(row_valid), 1);
      chk("present_row_data", 64'(row_data), 64'(rom_word(sheet, base + r)));
      chk("present_row_index", 64'(row_index), 64'(r));
      chk("present_row_last", 64'(row_last), 64'(r == height - 1));
      chk("present_rom_en", 64'(rom_en), 0);
      if (r == stop_row) begin
        row_ready = 1'b0;
        return;
      end
      if (r == 0 && stall > 0) begin
        for (int s = 0; s < stall; s++) begin
          step();
          chk("stall_row_valid", 64'(row_valid), 1);
          chk("stall_row_index", 64'(row_index), 0);
          chk("stall_row_data", 64'(row_data), 64'(rom_word(sheet, base)));
          chk("stall_rom_en", 64'(rom_en), 0);
        end
        row_ready = 1'b1;
      end
      step();
    end
    chk("done_req_ready", 64'(req_ready), 1);
    chk("done_row_valid", 64'(row_valid), 0);
    chk("done_rom_en", 64'(rom_en), 0);
    chk("done_rom_addr_hold", 64'(rom_addr), 64'(base + height - 1));
    chk("done_rom_sheet_hold", 64'(rom_sheet), 64'(sheet));
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_value = 4'd0;
    row_ready = 1'b0;
`ifdef GLYPH_ROW_READER_ABORT_EN
    abort     = 1'b0;
`endif
    step();
    step();
    check_reset("in_reset");
    reset = 1'b0;
    step();
    check_reset("after_reset");

    // Digit 3: rows 180..239 on the digit sheet
    run_glyph(4'd3, 180, 60, 0, 0, -1);
    // PM: rows 20..39 on sheet 1; Green: rows 20..39 on sheet 3
    run_glyph(4'd11, 20, 20, 1, 0, -1);
    run_glyph(4'd14, 20, 20, 3, 0, -1);

    // Invalid code: one-cycle err, no ROM read, stays idle, address held
    req_value = 4'd15;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    chk("inv_err_pulse", 64'(err), 1);
    chk("inv_rom_en", 64'(rom_en), 0);
    chk("inv_req_ready", 64'(req_ready), 1);
    chk("inv_rom_addr_hold", 64'(rom_addr), 39);
    step();
    chk("inv_err_clear", 64'(err), 0);
    chk("inv_rom_en2", 64'(rom_en), 0);
    chk("inv_req_ready2", 64'(req_ready), 1);

    // Digit 9 with a 5-cycle stall on row 0; last address 599
    run_glyph(4'd9, 540, 60, 0, 5, -1);
    chk("max_addr", 64'(rom_addr), 599);

    // Reset while presenting row 10 of digit 7, then digit 0 from address 0
    run_glyph(4'd7, 420, 60, 0, 0, 10);
    reset = 1'b1;
    step();
    check_reset("mid_reset");
    reset = 1'b0;
    step();
    check_reset("mid_reset_idle");
    run_glyph(4'd0, 0, 60, 0, 0, -1);

`ifdef GLYPH_ROW_READER_ABORT_EN
    // Abort coinciding with the row-5 handshake of digit 2
    run_glyph(4'd2, 120, 60, 0, 0, 5);
    row_ready = 1'b1;
    abort     = 1'b1;
    step();
    abort     = 1'b0;
    row_ready = 1'b0;
    chk("abort_row_valid", 64'(row_valid), 0);
    chk("abort_req_ready", 64'(req_ready), 1);
    chk("abort_rom_en", 64'(rom_en), 0);
    chk("abort_err", 64'(err), 0);
    step();
    chk("abort_no_row6", 64'(rom_en), 0);
    chk("abort_err2", 64'(err), 0);
    run_glyph(4'd10, 0, 20, 1, 0, -1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
